pipe_ctrl_gen: RTL and testbench

PIPE_CTRL_GEN -- requirements
Module: pipe_ctrl_gen

---
 rtl/pipe_ctrl_pkg.sv | 10 +
 rtl/pipe_ctrl_gen_sat_counter.sv | 12 +
 rtl/pipe_ctrl_gen.sv | 77 +++++++
 tb/tb_pipe_ctrl_gen.sv | 120 ++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: control codes and FSM states shared by the pipeline controller
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        CTRL_DEFAULT = 2'b00,
        CTRL_BLOCK   = 2'b01,
        CTRL_BUBBLE  = 2'b10,
        CTRL_BRANCH  = 2'b11
    } ctrl_e;
    typedef enum logic [2:0] {RUN, STALL, STALL_PEND, REPLAY, SETTLE} state_e;
endpackage

// File: rtl/pipe_ctrl_gen_sat_counter.sv
// sat_counter: event counter that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk)
        cnt <= !rst ? '0 : (en && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: stall/flush control codes for the pipeline from cache stalls and EX redirects
module pipe_ctrl_gen
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE  = 5,
    parameter int NSRC    = 2,
    parameter int FLUSH_N = 2,
    parameter int ADDR_W  = 64,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NSRC-1:0]     blk_req_i,
    input  logic [NSRC-1:0]     blk_ready_i,
    input  logic                redirect_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    output logic [2*NSTAGE-1:0] stage_ctrl_o,
    output logic [2*NSRC-1:0]   src_ctrl_o,
    output logic [ADDR_W-1:0]   pc_new_o,
    output logic                busy_o,
    output logic [CNT_W-1:0]    stall_cnt_o,
    output logic [CNT_W-1:0]    redirect_cnt_o
);
    localparam int OW = NSRC > 1 ? $clog2(NSRC) : 1;
    state_e state, state_nxt;
    logic [OW-1:0] owner, owner_nxt, own;
    logic [ADDR_W-1:0] pc_lat;
    logic req, take, stalled, issue;
    assign req     = |blk_req_i;
    assign take    = req && (state == RUN || state == SETTLE);
    assign stalled = state == STALL || state == STALL_PEND;
    assign issue   = (state == RUN && !req && redirect_i) || state == REPLAY;
    assign own     = take ? owner_nxt : owner;
    assign busy_o  = state != RUN;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= RUN;
            owner  <= '0;
            pc_lat <= '0;
        end else begin
            state <= state_nxt;
            if (take) owner <= owner_nxt;
            if (state == RUN && redirect_i) pc_lat <= redirect_pc_i;
        end
    end
    always_comb begin
        owner_nxt = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (blk_req_i[i]) owner_nxt = OW'(i);
        state_nxt = state;
        case (state)
            RUN:        state_nxt = req ? (redirect_i ? STALL_PEND : STALL) : redirect_i ? SETTLE : RUN;
            SETTLE:     state_nxt = req ? STALL : RUN;
            STALL:      state_nxt = blk_ready_i[owner] ? RUN : STALL;
            STALL_PEND: state_nxt = blk_ready_i[owner] ? REPLAY : STALL_PEND;
            REPLAY:     state_nxt = SETTLE;
            default:    state_nxt = RUN;
        endcase
    end
    // a fresh request blocks in the same cycle it is seen, before the owner is registered
    always_comb begin
        for (int i = 0; i < NSTAGE; i++)
            stage_ctrl_o[2*i +: 2] = (take || stalled) ? CTRL_BLOCK :
                                     !issue            ? CTRL_DEFAULT :
                                     i == 0            ? CTRL_BRANCH :
                                     i <= FLUSH_N      ? CTRL_BUBBLE : CTRL_DEFAULT;
        for (int i = 0; i < NSRC; i++)
            src_ctrl_o[2*i +: 2] = ((take || stalled) && OW'(i) != own) ? CTRL_BLOCK : CTRL_DEFAULT;
        pc_new_o = (state == RUN && issue) ? redirect_pc_i : pc_lat;
    end
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .en(stalled), .cnt(stall_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk(clk), .rst(rst), .en(issue), .cnt(redirect_cnt_o)
    );
endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// tb_pipe_ctrl_gen: directed scoreboard bench for pipe_ctrl_gen (4-bit counters to reach saturation)
module tb_pipe_ctrl_gen;
    logic        clk = 0;
    logic        rst = 0;
    logic [1:0]  blk_req = 0, blk_ready = 0;
    logic        redirect = 0;
    logic [63:0] redirect_pc = 0;
    logic [9:0]  stage_ctrl;
    logic [3:0]  src_ctrl;
    logic [63:0] pc_new;
    logic        busy;
    logic [3:0]  stall_cnt, redirect_cnt;
    int checks = 0, failures = 0;
    localparam logic [9:0] ALLB = 10'h155, RDR = 10'h02B;
    localparam logic [3:0] S0 = 4'b0100, S1 = 4'b0001;
    localparam logic [5:0] ALL = 6'h3f;
    typedef struct {
        string       nm;
        logic [5:0]  chk;
        logic [9:0]  stg;
        logic [3:0]  src;
        logic [63:0] pc;
        logic        busy;
        logic [3:0]  sc;
        logic [3:0]  rc;
    } exp_t;
    exp_t q[$];
    pipe_ctrl_gen #(.NSTAGE(5), .NSRC(2), .FLUSH_N(2), .ADDR_W(64), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .blk_req_i(blk_req), .blk_ready_i(blk_ready),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .stage_ctrl_o(stage_ctrl), .src_ctrl_o(src_ctrl), .pc_new_o(pc_new),
        .busy_o(busy), .stall_cnt_o(stall_cnt), .redirect_cnt_o(redirect_cnt)
    );
    always #5 clk = ~clk;
    task automatic cmp(input string nm, input string f, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s.%s got=%0h exp=%0h", nm, f, a, x);
        end
    endtask
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.chk[0]) cmp(e.nm, "stage_ctrl", 64'(stage_ctrl), 64'(e.stg));
            if (e.chk[1]) cmp(e.nm, "src_ctrl", 64'(src_ctrl), 64'(e.src));
            if (e.chk[2]) cmp(e.nm, "pc_new", pc_new, e.pc);
            if (e.chk[3]) cmp(e.nm, "busy", 64'(busy), 64'(e.busy));
            if (e.chk[4]) cmp(e.nm, "stall_cnt", 64'(stall_cnt), 64'(e.sc));
            if (e.chk[5]) cmp(e.nm, "redirect_cnt", 64'(redirect_cnt), 64'(e.rc));
        end
    end
    task automatic cyc(input string nm, input logic rn, input logic [1:0] rq, input logic [1:0] ry,
                       input logic rd, input logic [63:0] rpc, input logic [5:0] c,
                       input logic [9:0] stg, input logic [3:0] src, input logic [63:0] pc,
                       input logic b, input logic [3:0] sc, input logic [3:0] rc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rn; blk_req = rq; blk_ready = ry; redirect = rd; redirect_pc = rpc;
        e.nm = nm; e.chk = c; e.stg = stg; e.src = src; e.pc = pc; e.busy = b; e.sc = sc; e.rc = rc;
        q.push_back(e);
    endtask
    task automatic do_reset();
        cyc("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        do_reset();
        do_reset();
        cyc("reset_state", 1, 0, 0, 0, 0, ALL, 0, 0, 0, 0, 0, 0);
        // plain redirect; SETTLE must ignore a second redirect
        cyc("redir", 1, 0, 0, 1, 64'h8000_0040, ALL, RDR, 0, 64'h8000_0040, 0, 0, 0);
        cyc("settle", 1, 0, 0, 1, 64'hdead, ALL, 0, 0, 64'h8000_0040, 1, 0, 1);
        cyc("run_after", 1, 0, 0, 0, 0, ALL, 0, 0, 64'h8000_0040, 0, 0, 1);
        // dcache stall, ready in request cycle must not shorten it
        do_reset();
        cyc("dc_req", 1, 2'b01, 2'b01, 0, 0, ALL, ALLB, S0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            cyc("dc_stall", 1, 2'b01, k == 4 ? 2'b01 : 2'b00, 0, 0, ALL, ALLB, S0, 0, 1, 4'(k), 0);
        cyc("dc_done", 1, 0, 0, 0, 0, ALL, 0, 0, 0, 0, 5, 0);
        // simultaneous requests, dcache owns
        do_reset();
        cyc("both_req", 1, 2'b11, 0, 0, 0, ALL, ALLB, S0, 0, 0, 0, 0);
        cyc("ic_rdy1", 1, 2'b11, 2'b10, 0, 0, ALL, ALLB, S0, 0, 1, 0, 0);
        cyc("ic_rdy2", 1, 2'b11, 2'b10, 0, 0, ALL, ALLB, S0, 0, 1, 1, 0);
        cyc("dc_rdy", 1, 2'b11, 2'b01, 0, 0, ALL, ALLB, S0, 0, 1, 2, 0);
        cyc("both_done", 1, 0, 0, 0, 0, ALL, 0, 0, 0, 0, 3, 0);
        // icache stall with pending redirect then replay
        do_reset();
        cyc("pend_req", 1, 2'b10, 0, 1, 64'h1234, ALL, ALLB, S1, 0, 0, 0, 0);
        cyc("pend_hold", 1, 2'b10, 2'b01, 1, 64'h9999, ALL, ALLB, S1, 64'h1234, 1, 0, 0);
        cyc("pend_rdy", 1, 2'b10, 2'b10, 0, 0, ALL, ALLB, S1, 64'h1234, 1, 1, 0);
        cyc("replay", 1, 0, 0, 1, 64'h5555, ALL, RDR, 0, 64'h1234, 1, 2, 0);
        cyc("replay_settle", 1, 0, 0, 0, 0, ALL, 0, 0, 64'h1234, 1, 2, 1);
        cyc("replay_run", 1, 0, 0, 0, 0, ALL, 0, 0, 64'h1234, 0, 2, 1);
        // reset in STALL_PEND discards the pending redirect
        do_reset();
        cyc("e_req", 1, 2'b01, 0, 1, 64'habc, ALL, ALLB, S0, 0, 0, 0, 0);
        cyc("e_hold", 1, 2'b01, 0, 0, 0, ALL, ALLB, S0, 64'habc, 1, 0, 0);
        cyc("e_rst", 0, 2'b01, 0, 0, 0, ALL, ALLB, S0, 64'habc, 1, 1, 0);
        cyc("e_after", 1, 0, 2'b01, 0, 0, ALL, 0, 0, 0, 0, 0, 0);
        cyc("e_norep", 1, 0, 0, 0, 0, ALL, 0, 0, 0, 0, 0, 0);
        // long stall saturates the 4-bit stall counter
        do_reset();
        cyc("f_req", 1, 2'b01, 0, 0, 0, ALL, ALLB, S0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++)
            cyc("sat", 1, 2'b01, k == 19 ? 2'b01 : 2'b00, 0, 0, ALL, ALLB, S0, 0, 1, 4'(k > 15 ? 15 : k), 0);
        cyc("sat_done", 1, 0, 0, 0, 0, ALL, 0, 0, 0, 0, 15, 0);
        cyc("sat_hold", 1, 0, 0, 0, 0, ALL, 0, 0, 0, 0, 15, 0);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
